// File: rtl/ext_stream_pipe.sv
`timescale 1ns/1ps
// ext_stream_pipe: widens packed lanes with a per-beat zero/sign/one fill and
// registers them through a 2-entry skid buffer with valid/ready flow control.
module ext_stream_pipe #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 8,
    parameter int NUM_LANES = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic [1:0]                     Mode_In,
    input  logic                           In_Valid,
    output logic                           In_Ready,
    input  logic [NUM_LANES*IN_WIDTH-1:0]  Data_In,
    output logic                           Out_Valid,
    input  logic                           Out_Ready,
    output logic [NUM_LANES*OUT_WIDTH-1:0] Data_Out,
    output logic [CNT_WIDTH-1:0]           Beat_Count
);

    localparam int IW = NUM_LANES * IN_WIDTH;
    localparam int OW = NUM_LANES * OUT_WIDTH;

    if (OUT_WIDTH < IN_WIDTH) begin : g_param_check
        $error("ext_stream_pipe: OUT_WIDTH must be >= IN_WIDTH");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [OW-1:0]   out_data_r;
    logic [OW-1:0]   skid_data_r;
    logic [CNT_WIDTH-1:0] beat_count_r;

    logic [OW-1:0]   ext_data;
    logic            accept;
    logic            deliver;

    // Built bit by bit so OUT_WIDTH == IN_WIDTH needs no zero-width slice.
    function automatic logic [OW-1:0] extend(input logic [1:0] mode, input logic [IW-1:0] data);
        logic [OW-1:0] res;
        logic          fill;
        res = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            case (mode)
                2'b01:   fill = data[k*IN_WIDTH + IN_WIDTH - 1];
                2'b10:   fill = 1'b1;
                default: fill = 1'b0;
            endcase
            for (int b = 0; b < OUT_WIDTH; b++) begin
                res[k*OUT_WIDTH + b] = (b < IN_WIDTH) ? data[k*IN_WIDTH + b] : fill;
            end
        end
        return res;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        ext_data = extend(Mode_In, Data_In);
        accept   = In_Valid & in_ready_r;
        deliver  = out_valid_r & Out_Ready;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data_r  <= ext_data;
                        out_valid_r <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    case ({accept, deliver})
                        2'b10: begin
                            in_ready_r <= 1'b0;
                            state      <= TWO;
                        end
                        2'b01: begin
                            out_valid_r <= 1'b0;
                            state       <= EMPTY;
                        end
                        2'b11: out_data_r <= ext_data;
                        default: ;
                    endcase
                end
                TWO: begin
                    if (deliver) begin
                        out_data_r <= skid_data_r;
                        in_ready_r <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the skid payload has no reset; the occupancy state decides whether it is ever read.
    always_ff @(posedge Clk) begin
        if (state == ONE && accept && !deliver) begin
            skid_data_r <= ext_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            beat_count_r <= '0;
        end else if (deliver) begin
            beat_count_r <= beat_count_r + 1'b1;
        end
    end

    assign In_Ready   = in_ready_r;
    assign Out_Valid  = out_valid_r;
    assign Data_Out   = out_data_r;
    assign Beat_Count = beat_count_r;

endmodule

// File: tb/tb_ext_stream_pipe.sv
`timescale 1ns/1ps
// Bench for ext_stream_pipe: a 1-lane default instance and a 4-lane instance
// with a 4-bit counter, each checked by a scoreboard on delivered beats.
module tb_ext_stream_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance (1 lane, 4 -> 8, 16-bit counter).
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  mode;
    logic [3:0]  data_in;
    logic [7:0]  data_out;
    logic [15:0] beat_count;

    // Four-lane instance with a 4-bit counter.
    logic        reset4, in_valid4, in_ready4, out_valid4, out_ready4;
    logic [1:0]  mode4;
    logic [15:0] data_in4;
    logic [31:0] data_out4;
    logic [3:0]  beat_count4;

    ext_stream_pipe dut (
        .Clk(clk), .Reset(reset), .Mode_In(mode), .In_Valid(in_valid), .In_Ready(in_ready),
        .Data_In(data_in), .Out_Valid(out_valid), .Out_Ready(out_ready), .Data_Out(data_out),
        .Beat_Count(beat_count)
    );

    ext_stream_pipe #(.IN_WIDTH(4), .OUT_WIDTH(8), .NUM_LANES(4), .CNT_WIDTH(4)) dut4 (
        .Clk(clk), .Reset(reset4), .Mode_In(mode4), .In_Valid(in_valid4), .In_Ready(in_ready4),
        .Data_In(data_in4), .Out_Valid(out_valid4), .Out_Ready(out_ready4), .Data_Out(data_out4),
        .Beat_Count(beat_count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference extension for 4-bit lanes widened to 8 bits.
    function automatic logic [31:0] ext_model(input logic [1:0] m, input logic [15:0] d, input int lanes);
        logic [31:0] r;
        logic [3:0]  nib;
        logic [3:0]  hi;
        r = '0;
        for (int l = 0; l < lanes; l++) begin
            nib = d[l*4 +: 4];
            if (m == 2'b10 || (m == 2'b01 && nib[3])) hi = 4'hF;
            else hi = 4'h0;
            r[l*8 +: 8] = {hi, nib};
        end
        return r;
    endfunction

    // Scoreboards: expected beats are queued at acceptance and popped at delivery.
    logic [7:0]  sb_q[$];
    logic [31:0] sb_q4[$];
    int          exp_cnt = 0;
    int          exp_cnt4 = 0;
    bit          mon_en = 1'b0;
    bit          mon4_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("beat_count", {16'h0, beat_count}, exp_cnt);
            if (reset) begin
                sb_q.delete();
                exp_cnt = 0;
            end else if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %h expected no beat", data_out);
                end else begin
                    check("data_out", {24'h0, data_out}, {24'h0, sb_q.pop_front()});
                end
                exp_cnt = (exp_cnt + 1) % 65536;
            end
        end
    end

    always @(negedge clk) begin
        if (mon4_en) begin
            check("beat_count4", {28'h0, beat_count4}, exp_cnt4);
            if (reset4) begin
                sb_q4.delete();
                exp_cnt4 = 0;
            end else if (out_valid4 && out_ready4) begin
                if (sb_q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb4_unexpected: got %h expected no beat", data_out4);
                end else begin
                    check("data_out4", data_out4, sb_q4.pop_front());
                end
                exp_cnt4 = (exp_cnt4 + 1) % 16;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send(input logic [1:0] m, input logic [3:0] d, input logic [7:0] e);
        bit done;
        done = 1'b0;
        mode = m;
        data_in = d;
        in_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic send4(input logic [1:0] m, input logic [15:0] d, input logic [31:0] e);
        bit done;
        done = 1'b0;
        mode4 = m;
        data_in4 = d;
        in_valid4 = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            if (in_ready4) begin
                sb_q4.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid4 = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send4_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sb_q.size() != 0 || sb_q4.size() != 0) && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, sb_q.size() + sb_q4.size(), 0);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [3:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int start_cyc;

        vecs[0] = '{2'b00, 4'b0000, 8'b00000000};
        vecs[1] = '{2'b01, 4'b0101, 8'b00000101};
        vecs[2] = '{2'b00, 4'b1111, 8'b00001111};
        vecs[3] = '{2'b01, 4'b1010, 8'b11111010};
        vecs[4] = '{2'b10, 4'b1100, 8'b11111100};
        vecs[5] = '{2'b11, 4'b1010, 8'b00001010};
        vecs[6] = '{2'b10, 4'b0000, 8'b11110000};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; data_in = 4'h0;
        reset4 = 1'b1; in_valid4 = 1'b0; out_ready4 = 1'b1; mode4 = 2'b00; data_in4 = 16'h0;

        // Reset state
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_beat_count", beat_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Table vectors back to back with Out_Ready=1: one beat per cycle
        start_cyc = cyc;
        for (int i = 0; i < 7; i++) send(vecs[i].mode, vecs[i].din, vecs[i].dout);
        check("throughput_cycles", cyc - start_cyc, 7);
        drain("drain_table");
        check("count_after_table", beat_count, 7);

        // Back-pressure: A and B fill the buffer, C must wait
        out_ready = 1'b0;
        mode = 2'b00; data_in = 4'h3; in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_a", in_ready, 1);
        sb_q.push_back(8'h03);
        @(posedge clk); #1;
        mode = 2'b01; data_in = 4'h9;
        @(negedge clk);
        check("bp_latency_valid", out_valid, 1);
        check("bp_latency_data", data_out, 8'h03);
        check("bp_ready_b", in_ready, 1);
        sb_q.push_back(8'hF9);
        @(posedge clk); #1;
        mode = 2'b10; data_in = 4'h5;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_ready_full", in_ready, 0);
            check("bp_hold_data", data_out, 8'h03);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_valid_a", out_valid, 1);
        check("rel_ready_a", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rel_valid_b", out_valid, 1);
        check("rel_ready_c", in_ready, 1);
        sb_q.push_back(8'hF5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rel_valid_c", out_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rel_empty_valid", out_valid, 0);
        check("rel_sb_empty", sb_q.size(), 0);
        check("count_after_bp", beat_count, 10);

        // Reset while full, Out_Ready=1: buffered beats are discarded
        @(posedge clk); #1;
        out_ready = 1'b0;
        mode = 2'b00; data_in = 4'h6; in_valid = 1'b1;
        @(negedge clk); sb_q.push_back(8'h06);
        @(posedge clk); #1;
        data_in = 4'h7;
        @(negedge clk); sb_q.push_back(8'h07);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("two_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_ready", in_ready, 1);
        check("rst_mid_count", beat_count, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 0);
        end

        // Four lanes
        @(posedge clk); #1;
        mon4_en = 1'b1;
        @(posedge clk); #1;
        reset4 = 1'b0;
        send4(2'b01, 16'h8F70, 32'hF8FF0700);
        send4(2'b10, 16'h0123, 32'hF0F1F2F3);
        send4(2'b00, 16'h8F70, 32'h08_0F_07_00);
        drain("drain_lanes");

        // Counter wrap with 4-bit counter: 17 deliveries end at 1
        reset4 = 1'b1;
        @(posedge clk); #1;
        reset4 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            logic [15:0] d;
            logic [1:0]  m;
            d = 16'(i * 16'h1357);
            m = 2'(i % 4);
            send4(m, d, ext_model(m, d, 4));
        end
        drain("drain_wrap");
        check("wrap_final_count", beat_count4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
